// File: rtl/semicpu_pkg.sv
// Shared definitions for the SemiCPU issue controller: opcodes, instruction
// field positions, FSM state encoding and the field widths.
package semicpu_pkg;

  localparam int XLEN        = 32;
  localparam int REG_IDX_W   = 4;
  localparam int IMM_FIELD_W = 17;
  localparam int OPC_W       = 3;

  // Instruction word layout
  localparam int OPC_HI = 31;
  localparam int OPC_LO = 29;
  localparam int RD_HI  = 28;
  localparam int RD_LO  = 25;
  localparam int RS1_HI = 24;
  localparam int RS1_LO = 21;
  localparam int RS2_HI = 20;
  localparam int RS2_LO = 17;

  // Opcodes (also forwarded unchanged to the ALU)
  localparam logic [OPC_W-1:0] OP_NOOP0  = 3'b000;
  localparam logic [OPC_W-1:0] OP_NOOP1  = 3'b001;
  localparam logic [OPC_W-1:0] OP_ADD    = 3'b010;
  localparam logic [OPC_W-1:0] OP_SUB    = 3'b011;
  localparam logic [OPC_W-1:0] OP_SHIFTL = 3'b100;
  localparam logic [OPC_W-1:0] OP_SHIFTR = 3'b101;
  localparam logic [OPC_W-1:0] OP_ADDI   = 3'b110;
  localparam logic [OPC_W-1:0] OP_SUBI   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_WB     = 2'd3
  } state_t;

  // Immediate forms take operand B from the zero-extended imm field
  function automatic logic is_imm_op(input logic [OPC_W-1:0] op);
    return (op == OP_ADDI) || (op == OP_SUBI);
  endfunction

  // Both NOOP encodings retire without touching the register file
  function automatic logic writes_reg(input logic [OPC_W-1:0] op);
    return (op != OP_NOOP0) && (op != OP_NOOP1);
  endfunction

endpackage

// File: rtl/semicpu_regfile.sv
// REG_COUNT x 32 register file: two combinational operand read ports, one
// combinational debug read port, one synchronous write port. r0 is
// hard-wired to zero and the whole array clears asynchronously on reset.
module semicpu_regfile
  import semicpu_pkg::*;
#(
  parameter int REG_COUNT = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we,
  input  logic [REG_IDX_W-1:0] waddr,
  input  logic [XLEN-1:0]      wdata,
  input  logic [REG_IDX_W-1:0] raddr1,
  output logic [XLEN-1:0]      rdata1,
  input  logic [REG_IDX_W-1:0] raddr2,
  output logic [XLEN-1:0]      rdata2,
  input  logic [REG_IDX_W-1:0] dbg_addr,
  output logic [XLEN-1:0]      dbg_data
);

  logic [XLEN-1:0] regs [REG_COUNT];

  // Storage: async clear, synchronous write that never lands in r0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  // Read ports: r0 is forced to zero; a same-cycle write shows the old value
  always_comb begin
    rdata1   = (raddr1   == '0) ? '0 : regs[raddr1];
    rdata2   = (raddr2   == '0) ? '0 : regs[raddr2];
    dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];
  end

endmodule

// File: rtl/semicpu_issue_ctrl.sv
// SemiCPU decode/issue/writeback controller. One instruction at a time walks
// IDLE -> DECODE -> EXEC -> WB, so a new instruction can be taken every
// 4 cycles. Optional feature macro: SEMICPU_RETIRE_COUNT_EN adds a 32-bit
// wrapping retire counter output (retire_count).
//
// Handshake: an instruction transfers on a rising edge where instr_valid and
// instr_ready are both 1. instr_ready is 1 only in IDLE (and never while
// rst_n is low); instr is latched at the transfer edge and may change freely
// afterwards. retire_valid is a one-cycle pulse with no back-pressure.
module semicpu_issue_ctrl
  import semicpu_pkg::*;
#(
  parameter int REG_COUNT = 16,
  parameter int IMM_W     = IMM_FIELD_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 instr_valid,
  output logic                 instr_ready,
  input  logic [XLEN-1:0]      instr,
  output logic [XLEN-1:0]      alu_a,
  output logic [XLEN-1:0]      alu_b,
  output logic [OPC_W-1:0]     alu_opcode,
  input  logic [XLEN-1:0]      alu_result,
  output logic                 retire_valid,
  output logic [REG_IDX_W-1:0] retire_rd,
  output logic [XLEN-1:0]      retire_value,
`ifdef SEMICPU_RETIRE_COUNT_EN
  output logic [XLEN-1:0]      retire_count,
`endif
  input  logic [REG_IDX_W-1:0] dbg_addr,
  output logic [XLEN-1:0]      dbg_data,
  output logic [1:0]           dbg_state
);

  state_t state_q, state_d;

  logic [XLEN-1:0]      instr_q;
  logic [XLEN-1:0]      result_q;
  logic [OPC_W-1:0]     f_op;
  logic [REG_IDX_W-1:0] f_rd, f_rs1, f_rs2;
  logic [XLEN-1:0]      imm_ext;
  logic [XLEN-1:0]      rs1_data, rs2_data;
  logic                 rf_we;

  assign f_op    = instr_q[OPC_HI:OPC_LO];
  assign f_rd    = instr_q[RD_HI:RD_LO];
  assign f_rs1   = instr_q[RS1_HI:RS1_LO];
  assign f_rs2   = instr_q[RS2_HI:RS2_LO];
  assign imm_ext = {{(XLEN-IMM_W){1'b0}}, instr_q[IMM_W-1:0]};

  assign dbg_state = state_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state: wait for a transfer, then three fixed steps
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (instr_valid) state_d = ST_DECODE;
      ST_DECODE: state_d = ST_EXEC;
      ST_EXEC:   state_d = ST_WB;
      ST_WB:     state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: ready only in IDLE out of reset, write only in WB
  always_comb begin
    instr_ready = rst_n && (state_q == ST_IDLE);
    rf_we       = (state_q == ST_WB) && writes_reg(f_op);
  end

  // Datapath: latch instr, register ALU inputs, capture result, retire
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q      <= '0;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_opcode   <= '0;
      result_q     <= '0;
      retire_valid <= 1'b0;
      retire_rd    <= '0;
      retire_value <= '0;
    end else begin
      retire_valid <= (state_q == ST_WB);
      case (state_q)
        ST_IDLE: begin
          if (instr_valid) instr_q <= instr;
        end
        ST_DECODE: begin
          alu_a      <= rs1_data;
          alu_b      <= is_imm_op(f_op) ? imm_ext : rs2_data;
          alu_opcode <= f_op;
        end
        ST_EXEC: begin
          result_q <= alu_result;
        end
        ST_WB: begin
          retire_rd    <= f_rd;
          retire_value <= result_q;
        end
        default: ;
      endcase
    end
  end

`ifdef SEMICPU_RETIRE_COUNT_EN
  // Retire counter steps with every retire pulse and wraps naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 retire_count <= '0;
    else if (state_q == ST_WB)  retire_count <= retire_count + 32'd1;
  end
`endif

  semicpu_regfile #(.REG_COUNT(REG_COUNT)) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (rf_we),
    .waddr    (f_rd),
    .wdata    (result_q),
    .raddr1   (f_rs1),
    .rdata1   (rs1_data),
    .raddr2   (f_rs2),
    .rdata2   (rs2_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

endmodule

// File: tb/tb_semicpu_issue_ctrl.sv
// Directed bench for semicpu_issue_ctrl with a behavioural ALU attached.
module tb_semicpu_issue_ctrl;

  logic        clk;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] alu_a, alu_b;
  logic [2:0]  alu_opcode;
  logic [31:0] alu_result;
  logic        retire_valid;
  logic [3:0]  retire_rd;
  logic [31:0] retire_value;
  logic [3:0]  dbg_addr;
  logic [31:0] dbg_data;
  logic [1:0]  dbg_state;
`ifdef SEMICPU_RETIRE_COUNT_EN
  logic [31:0] retire_count;
`endif

  int n_cmp = 0;
  int n_fail = 0;
  int n_retired = 0;
  logic [31:0] exp_q[$];

  semicpu_issue_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr        (instr),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_opcode   (alu_opcode),
    .alu_result   (alu_result),
    .retire_valid (retire_valid),
    .retire_rd    (retire_rd),
    .retire_value (retire_value),
`ifdef SEMICPU_RETIRE_COUNT_EN
    .retire_count (retire_count),
`endif
    .dbg_addr     (dbg_addr),
    .dbg_data     (dbg_data),
    .dbg_state    (dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU
  always_comb begin
    case (alu_opcode)
      3'b010, 3'b110: alu_result = alu_a + alu_b;
      3'b011, 3'b111: alu_result = alu_a - alu_b;
      3'b100:         alu_result = alu_a << alu_b;
      3'b101:         alu_result = alu_a >> alu_b;
      default:        alu_result = 32'd0;
    endcase
  end

  // Driver: issue one instruction starting from a negedge, return the ALU
  // inputs seen in EXEC and the retire fields; lat counts negedges after the
  // transfer edge until retire_valid is seen (99 on timeout). Ends on the
  // negedge where retire_valid is high.
  task automatic run_instr(input logic [31:0] iw, output logic [2:0] opc,
                           output logic [31:0] a, output logic [31:0] b,
                           output logic [3:0] rd, output logic [31:0] val,
                           output int lat);
    int w;
    w = 0;
    while (!instr_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    instr_valid = 1'b1;
    instr = iw;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    instr = $urandom;
    lat = 99;
    opc = 'x; a = 'x; b = 'x; rd = 'x; val = 'x;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (i == 2) begin
        opc = alu_opcode; a = alu_a; b = alu_b;
      end
      if (retire_valid) begin
        lat = i; rd = retire_rd; val = retire_value;
        break;
      end
    end
    n_retired++;
  endtask

  task automatic read_dbg(input logic [3:0] addr, output logic [31:0] d);
    dbg_addr = addr;
    #1;
    d = dbg_data;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst_n = 1'b0;
    instr_valid = 1'b0;
    instr = 32'd0;
    dbg_addr = 4'd0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (instr_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready_low: got %b want 0", instr_ready); end
    n_cmp++;
    if (retire_valid !== 1'b0) begin n_fail++; $display("FAIL rst_retire_valid: got %b want 0", retire_valid); end
    n_cmp++;
    if ({alu_a, alu_b, alu_opcode} !== 67'd0) begin
      n_fail++; $display("FAIL rst_alu: got a=%h b=%h op=%b want 0", alu_a, alu_b, alu_opcode);
    end
    n_cmp++;
    if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL rst_state: got %0d want 0", dbg_state); end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (instr_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready_high: got %b want 1", instr_ready); end
    n_cmp++;
    if ({retire_rd, retire_value} !== 36'd0) begin
      n_fail++; $display("FAIL rst_retire_fields: got rd=%0d v=%h want 0", retire_rd, retire_value);
    end
    for (int r = 0; r < 16; r++) begin
      read_dbg(r[3:0], d);
      n_cmp++;
      if (d !== 32'd0) begin n_fail++; $display("FAIL rst_reg%0d: got %h want 0", r, d); end
    end
`ifdef SEMICPU_RETIRE_COUNT_EN
    n_cmp++;
    if (retire_count !== 32'd0) begin n_fail++; $display("FAIL rst_count: got %0d want 0", retire_count); end
`endif
  endtask

  task automatic test_addi();
    logic [2:0] opc; logic [31:0] a, b, v, d; logic [3:0] rd; int lat;
    run_instr(32'hC2000005, opc, a, b, rd, v, lat);
    n_cmp++;
    if (lat !== 4) begin n_fail++; $display("FAIL addi1_latency: got %0d want 4", lat); end
    n_cmp++;
    if (opc !== 3'b110 || a !== 32'd0 || b !== 32'd5) begin
      n_fail++; $display("FAIL addi1_alu: got op=%b a=%h b=%h want 110/0/5", opc, a, b);
    end
    n_cmp++;
    if (rd !== 4'd1 || v !== 32'd5) begin n_fail++; $display("FAIL addi1_retire: got rd=%0d v=%h want 1/5", rd, v); end
    @(negedge clk);
    n_cmp++;
    if (retire_valid !== 1'b0) begin n_fail++; $display("FAIL retire_pulse_width: got %b want 0", retire_valid); end
    run_instr(32'hC4000003, opc, a, b, rd, v, lat);
    n_cmp++;
    if (rd !== 4'd2 || v !== 32'd3) begin n_fail++; $display("FAIL addi2_retire: got rd=%0d v=%h want 2/3", rd, v); end
    read_dbg(4'd1, d);
    n_cmp++;
    if (d !== 32'd5) begin n_fail++; $display("FAIL dbg_r1: got %h want 5", d); end
    read_dbg(4'd2, d);
    n_cmp++;
    if (d !== 32'd3) begin n_fail++; $display("FAIL dbg_r2: got %h want 3", d); end
  endtask

  task automatic test_sub();
    logic [2:0] opc; logic [31:0] a, b, v, d; logic [3:0] rd; int lat;
    run_instr(32'h66240000, opc, a, b, rd, v, lat);
    n_cmp++;
    if (opc !== 3'b011 || a !== 32'd5 || b !== 32'd3) begin
      n_fail++; $display("FAIL sub_alu: got op=%b a=%h b=%h want 011/5/3", opc, a, b);
    end
    n_cmp++;
    if (rd !== 4'd3 || v !== 32'd2) begin n_fail++; $display("FAIL sub_retire: got rd=%0d v=%h want 3/2", rd, v); end
    n_cmp++;
    if (alu_a !== 32'd5 || alu_b !== 32'd3) begin
      n_fail++; $display("FAIL alu_hold_idle: got a=%h b=%h want 5/3", alu_a, alu_b);
    end
    read_dbg(4'd3, d);
    n_cmp++;
    if (d !== 32'd2) begin n_fail++; $display("FAIL dbg_r3: got %h want 2", d); end
  endtask

  task automatic test_shift_wrap();
    logic [2:0] opc; logic [31:0] a, b, v, d; logic [3:0] rd; int lat;
    run_instr(32'h88240000, opc, a, b, rd, v, lat);
    n_cmp++;
    if (opc !== 3'b100 || v !== 32'd40) begin n_fail++; $display("FAIL shl_retire: got op=%b v=%h want 100/28", opc, v); end
    read_dbg(4'd4, d);
    n_cmp++;
    if (d !== 32'd40) begin n_fail++; $display("FAIL dbg_r4: got %h want 28", d); end
    run_instr(32'hEA000001, opc, a, b, rd, v, lat);
    n_cmp++;
    if (rd !== 4'd5 || v !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL subi_wrap: got rd=%0d v=%h want 5/ffffffff", rd, v); end
    read_dbg(4'd5, d);
    n_cmp++;
    if (d !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL dbg_r5: got %h want ffffffff", d); end
  endtask

  task automatic test_r0_noop();
    logic [2:0] opc; logic [31:0] a, b, v, d; logic [3:0] rd; int lat;
    run_instr(32'hC0000007, opc, a, b, rd, v, lat);
    n_cmp++;
    if (lat !== 4 || rd !== 4'd0 || v !== 32'd7) begin
      n_fail++; $display("FAIL r0_retire: got lat=%0d rd=%0d v=%h want 4/0/7", lat, rd, v);
    end
    read_dbg(4'd0, d);
    n_cmp++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL r0_stays_zero: got %h want 0", d); end
    run_instr(32'h00000000, opc, a, b, rd, v, lat);
    n_cmp++;
    if (lat !== 4 || rd !== 4'd0 || v !== 32'd0) begin
      n_fail++; $display("FAIL noop0_retire: got lat=%0d rd=%0d v=%h want 4/0/0", lat, rd, v);
    end
    // NOOP (001) naming rd=r3, rs1=r1, rs2=r2: R-type operands, no write
    run_instr(32'h26240000, opc, a, b, rd, v, lat);
    n_cmp++;
    if (opc !== 3'b001 || a !== 32'd5 || b !== 32'd3) begin
      n_fail++; $display("FAIL noop1_alu: got op=%b a=%h b=%h want 001/5/3", opc, a, b);
    end
    n_cmp++;
    if (lat !== 4 || rd !== 4'd3 || v !== 32'd0) begin
      n_fail++; $display("FAIL noop1_retire: got lat=%0d rd=%0d v=%h want 4/3/0", lat, rd, v);
    end
    read_dbg(4'd3, d);
    n_cmp++;
    if (d !== 32'd2) begin n_fail++; $display("FAIL noop1_no_write: got %h want 2", d); end
  endtask

  // ADDI r8 = 0x1FFFF: full-width imm zero-extends; dbg shows old value in WB
  task automatic test_dbg_timing();
    logic [31:0] d;
    instr_valid = 1'b1;
    instr = 32'hD001FFFF;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    instr = $urandom;
    repeat (3) @(negedge clk);
    read_dbg(4'd8, d);
    n_cmp++;
    if (d !== 32'd0 || retire_valid !== 1'b0 || dbg_state !== 2'd3) begin
      n_fail++; $display("FAIL dbg_in_wb: got d=%h rv=%b st=%0d want 0/0/3", d, retire_valid, dbg_state);
    end
    @(negedge clk);
    read_dbg(4'd8, d);
    n_cmp++;
    if (d !== 32'h0001FFFF) begin n_fail++; $display("FAIL dbg_after_wb: got %h want 0001ffff", d); end
    n_cmp++;
    if (retire_valid !== 1'b1 || retire_rd !== 4'd8 || retire_value !== 32'h0001FFFF) begin
      n_fail++; $display("FAIL imm_zext_retire: got rv=%b rd=%0d v=%h want 1/8/0001ffff", retire_valid, retire_rd, retire_value);
    end
    n_retired++;
  endtask

  // instr_valid held high: ready must appear once every 4 cycles
  task automatic test_back_to_back();
    int ready_cnt, bad_pos, retired;
    logic [31:0] k, exp;
    logic r;
    ready_cnt = 0; bad_pos = 0; retired = 0; k = 32'd1;
    @(negedge clk);
    instr = 32'hCC000000 | k;
    for (int i = 0; i < 20; i++) begin
      instr_valid = (i < 16);
      r = instr_ready;
      if (i < 16 && r) begin
        ready_cnt++;
        if (i % 4 != 0) bad_pos++;
      end
      if (retire_valid) begin
        retired++;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEADBEEF;
        n_cmp++;
        if (retire_value !== exp || retire_rd !== 4'd6) begin
          n_fail++; $display("FAIL b2b_retire: got rd=%0d v=%h want 6/%h", retire_rd, retire_value, exp);
        end
      end
      @(posedge clk);
      if (r && instr_valid) begin
        exp_q.push_back(k);
        #1;
        k = k + 32'd1;
        instr = 32'hCC000000 | k;
      end
      @(negedge clk);
    end
    instr_valid = 1'b0;
    n_retired += retired;
    n_cmp++;
    if (ready_cnt !== 4 || bad_pos !== 0) begin
      n_fail++; $display("FAIL b2b_ready_rate: got %0d ready (%0d misplaced) want 4/0", ready_cnt, bad_pos);
    end
    n_cmp++;
    if (retired !== 4 || exp_q.size() !== 0) begin
      n_fail++; $display("FAIL b2b_retire_count: got %0d left %0d want 4/0", retired, exp_q.size());
    end
  endtask

`ifdef SEMICPU_RETIRE_COUNT_EN
  task automatic test_retire_count();
    n_cmp++;
    if (retire_count !== n_retired) begin
      n_fail++; $display("FAIL retire_count: got %0d want %0d", retire_count, n_retired);
    end
  endtask
`endif

  // Reset asserted while an ADDI r7 is in EXEC: no retire, regfile clears
  task automatic test_reset_mid();
    logic [31:0] d;
    int seen;
    seen = 0;
    instr_valid = 1'b1;
    instr = 32'hCE000009;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (dbg_state !== 2'd2) begin n_fail++; $display("FAIL mid_in_exec: got %0d want 2", dbg_state); end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (instr_ready !== 1'b0 || dbg_state !== 2'd0) begin
      n_fail++; $display("FAIL mid_rst_state: got rdy=%b st=%0d want 0/0", instr_ready, dbg_state);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (retire_valid) seen++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (retire_valid) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin n_fail++; $display("FAIL mid_no_retire: got %0d pulses want 0", seen); end
    n_cmp++;
    if (instr_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready_after: got %b want 1", instr_ready); end
    for (int r = 0; r < 16; r++) begin
      read_dbg(r[3:0], d);
      n_cmp++;
      if (d !== 32'd0) begin n_fail++; $display("FAIL mid_reg%0d: got %h want 0", r, d); end
    end
`ifdef SEMICPU_RETIRE_COUNT_EN
    n_cmp++;
    if (retire_count !== 32'd0) begin n_fail++; $display("FAIL mid_count: got %0d want 0", retire_count); end
`endif
  endtask

  initial begin
    test_reset();
    test_addi();
    test_sub();
    test_shift_wrap();
    test_r0_noop();
    test_dbg_timing();
    test_back_to_back();
`ifdef SEMICPU_RETIRE_COUNT_EN
    test_retire_count();
`endif
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Global time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
